// File: rtl/miner_pkg.sv
// ---------------------------------------------------------------------------
// miner_pkg
// Shared definitions for the miner job scheduler: header and nonce widths,
// the scheduler state encoding and the per-core field offset helper used to
// slice the packed per-core nonce buses.
// ---------------------------------------------------------------------------
package miner_pkg;

    localparam int HDR_W   = 640;
    localparam int NONCE_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        REPORT
    } state_t;

    // LSB position of core `core` inside a packed CORES*NONCE_W bus.
    function automatic int nonceLsb(input int core);
        return core * NONCE_W;
    endfunction

endpackage

// File: rtl/miner_scheduler_if.sv
// ---------------------------------------------------------------------------
// miner_scheduler_if
// Bundles the scheduler's job, core-array and result channels.
//   job_*      host -> scheduler job offer (valid/ready)
//   abort      host kill of the running job
//   core_*     scheduler <-> miner array (reset, header, nonce starts,
//              found flags, running nonces)
//   res_*      scheduler -> host result record (valid/ready)
//   busy       scheduler is in LOAD or RUN
// Modport master is the scheduler side, slave the host/array side.
// ---------------------------------------------------------------------------
interface miner_scheduler_if
    import miner_pkg::*;
#(
    parameter int CORES = 4
);

    localparam int IDX_W = (CORES > 1) ? $clog2(CORES) : 1;

    logic                     job_valid;
    logic                     job_ready;
    logic [HDR_W-1:0]         job_block;
    logic [NONCE_W-1:0]       job_start;
    logic [NONCE_W-1:0]       job_last;
    logic                     abort;
    logic                     core_reset;
    logic [HDR_W-1:0]         core_block;
    logic [CORES*NONCE_W-1:0] core_nonce_start;
    logic [CORES-1:0]         core_found;
    logic [CORES*NONCE_W-1:0] core_nonce;
    logic                     res_valid;
    logic                     res_ready;
    logic                     res_hit;
    logic [NONCE_W-1:0]       res_nonce;
    logic [IDX_W-1:0]         res_core;
    logic                     busy;

    modport master (
        input  job_valid, job_block, job_start, job_last, abort,
               core_found, core_nonce, res_ready,
        output job_ready, core_reset, core_block, core_nonce_start,
               res_valid, res_hit, res_nonce, res_core, busy
    );

    modport slave (
        output job_valid, job_block, job_start, job_last, abort,
               core_found, core_nonce, res_ready,
        input  job_ready, core_reset, core_block, core_nonce_start,
               res_valid, res_hit, res_nonce, res_core, busy
    );

endinterface

// File: rtl/miner_found_pick.sv
// ---------------------------------------------------------------------------
// miner_found_pick
// Combinational lowest-index priority picker over the (already masked)
// per-core found flags.
//   i_found  CORES flags
//   i_nonce  packed per-core nonce_out values
//   o_any    at least one flag set
//   o_idx    lowest set index
//   o_nonce  nonce_out of that core
// ---------------------------------------------------------------------------
module miner_found_pick
    import miner_pkg::*;
#(
    parameter int CORES = 4,
    parameter int IDX_W = 2
) (
    input  logic [CORES-1:0]         i_found,
    input  logic [CORES*NONCE_W-1:0] i_nonce,
    output logic                     o_any,
    output logic [IDX_W-1:0]         o_idx,
    output logic [NONCE_W-1:0]       o_nonce
);

    // Scan from the top down so the lowest set index is written last and wins.
    always_comb begin
        o_any   = 1'b0;
        o_idx   = '0;
        o_nonce = '0;
        for (int i = CORES - 1; i >= 0; i--) begin
            if (i_found[i]) begin
                o_any   = 1'b1;
                o_idx   = IDX_W'(i);
                o_nonce = i_nonce[nonceLsb(i) +: NONCE_W];
            end
        end
    end

endmodule

// File: rtl/miner_scheduler.sv
// ---------------------------------------------------------------------------
// miner_scheduler
// Job sequencer for a bank of CORES miner cores sharing one header. Accepts a
// job, holds the cores in reset for LOAD_CYC cycles with interleaved nonce
// starts, sweeps until the first unmasked found flag or range exhaustion, and
// returns one result record.
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      miner_scheduler_if.master (job, abort, core array, result, busy)
// ---------------------------------------------------------------------------
module miner_scheduler
    import miner_pkg::*;
#(
    parameter int CORES     = 4,
    parameter int FOUND_LAG = 1,
    parameter int LOAD_CYC  = 2
) (
    input logic                clk,
    input logic                reset_n,
    miner_scheduler_if.master  bus
);

    localparam int IDX_W    = (CORES > 1) ? $clog2(CORES) : 1;
    localparam int MASK_CYC = FOUND_LAG + 1;
    localparam int LCNT_W   = (LOAD_CYC > 1) ? $clog2(LOAD_CYC) : 1;
    localparam int MCNT_W   = $clog2(MASK_CYC + 1);
    // A core's nonce_out has already moved FOUND_LAG steps of CORES past the hit.
    localparam logic [NONCE_W-1:0] LAG_OFFSET = NONCE_W'(FOUND_LAG * CORES);

    state_t                   r_state;
    logic [LCNT_W-1:0]        r_loadCnt;
    logic [MCNT_W-1:0]        r_runCnt;
    logic [NONCE_W:0]         r_swept;
    logic [NONCE_W:0]         r_span;
    logic [HDR_W-1:0]         r_block;
    logic [CORES*NONCE_W-1:0] r_nonceStart;
    logic                     r_jobReady;
    logic                     r_coreReset;
    logic                     r_busy;
    logic                     r_resValid;
    logic                     r_resHit;
    logic [NONCE_W-1:0]       r_resNonce;
    logic [IDX_W-1:0]         r_resCore;

    logic                     w_unmasked;
    logic [CORES-1:0]         w_found;
    logic                     w_pickAny;
    logic [IDX_W-1:0]         w_pickIdx;
    logic [NONCE_W-1:0]       w_pickNonce;
    logic                     w_exhausted;

    // Freshly released cores still show stale found flags, so ignore them
    // until the pipeline has produced real results.
    assign w_unmasked  = (r_runCnt >= MCNT_W'(MASK_CYC));
    assign w_found     = bus.core_found & {CORES{w_unmasked}};
    assign w_exhausted = (r_swept >= r_span);

    miner_found_pick #(
        .CORES (CORES),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_found (w_found),
        .i_nonce (bus.core_nonce),
        .o_any   (w_pickAny),
        .o_idx   (w_pickIdx),
        .o_nonce (w_pickNonce)
    );

    // Scheduler FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_loadCnt    <= '0;
            r_runCnt     <= '0;
            r_swept      <= '0;
            r_span       <= '0;
            r_block      <= '0;
            r_nonceStart <= '0;
            r_jobReady   <= 1'b1;
            r_coreReset  <= 1'b1;
            r_busy       <= 1'b0;
            r_resValid   <= 1'b0;
            r_resHit     <= 1'b0;
            r_resNonce   <= '0;
            r_resCore    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.job_valid && r_jobReady) begin
                        r_state    <= LOAD;
                        r_jobReady <= 1'b0;
                        r_busy     <= 1'b1;
                        r_loadCnt  <= '0;
                        r_block    <= bus.job_block;
                        // Span is computed in 33 bits so a full 2^32 range fits.
                        r_span     <= {1'b0, bus.job_last} - {1'b0, bus.job_start}
                                      + (NONCE_W+1)'(1);
                        for (int i = 0; i < CORES; i++) begin
                            r_nonceStart[nonceLsb(i) +: NONCE_W] <= bus.job_start + NONCE_W'(i);
                        end
                    end
                end
                LOAD: begin
                    if (bus.abort) begin
                        r_state    <= IDLE;
                        r_jobReady <= 1'b1;
                        r_busy     <= 1'b0;
                    end else if (r_loadCnt == LCNT_W'(LOAD_CYC - 1)) begin
                        r_state     <= RUN;
                        r_coreReset <= 1'b0;
                        r_swept     <= '0;
                        r_runCnt    <= '0;
                    end else begin
                        r_loadCnt <= r_loadCnt + LCNT_W'(1);
                    end
                end
                RUN: begin
                    if (bus.abort) begin
                        r_state     <= IDLE;
                        r_jobReady  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_coreReset <= 1'b1;
                    end else if (w_pickAny || w_exhausted) begin
                        // A hit in the exhaustion cycle still counts as a hit.
                        r_state     <= REPORT;
                        r_busy      <= 1'b0;
                        r_coreReset <= 1'b1;
                        r_resValid  <= 1'b1;
                        r_resHit    <= w_pickAny;
                        r_resNonce  <= w_pickAny ? (w_pickNonce - LAG_OFFSET) : '0;
                        r_resCore   <= w_pickAny ? w_pickIdx : '0;
                    end else begin
                        r_swept <= r_swept + (NONCE_W+1)'(CORES);
                        if (!w_unmasked) begin
                            r_runCnt <= r_runCnt + MCNT_W'(1);
                        end
                    end
                end
                REPORT: begin
                    if (bus.res_ready) begin
                        r_state    <= IDLE;
                        r_resValid <= 1'b0;
                        r_jobReady <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_jobReady  <= 1'b1;
                    r_coreReset <= 1'b1;
                    r_busy      <= 1'b0;
                    r_resValid  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.job_ready        = r_jobReady;
    assign bus.core_reset       = r_coreReset;
    assign bus.core_block       = r_block;
    assign bus.core_nonce_start = r_nonceStart;
    assign bus.res_valid        = r_resValid;
    assign bus.res_hit          = r_resHit;
    assign bus.res_nonce        = r_resNonce;
    assign bus.res_core         = r_resCore;
    assign bus.busy             = r_busy;

endmodule

// File: tb/tb_miner_scheduler.sv
// ---------------------------------------------------------------------------
// tb_miner_scheduler
// Directed self-checking bench for miner_scheduler with CORES=4, FOUND_LAG=1,
// LOAD_CYC=2. The bench plays both host and miner array through the
// interface, driving and sampling on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_miner_scheduler;
    import miner_pkg::*;

    localparam int CORES = 4;

    logic             clk;
    logic             reset_n;
    int               checks = 0;
    int               errors = 0;
    logic [HDR_W-1:0] blk;

    miner_scheduler_if #(.CORES(CORES)) bus();

    miner_scheduler #(
        .CORES     (CORES),
        .FOUND_LAG (1),
        .LOAD_CYC  (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic advance(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic setNonce(input int core, input logic [31:0] value);
        bus.core_nonce[core*32 +: 32] = value;
    endtask

    // Offers one job; returns at the first falling edge after the accept edge.
    task automatic applyStimulus(input logic [31:0] start, input logic [31:0] last);
        @(negedge clk);
        bus.job_valid = 1'b1;
        bus.job_start = start;
        bus.job_last  = last;
        bus.job_block = blk;
        @(posedge clk);
        @(negedge clk);
        bus.job_valid = 1'b0;
    endtask

    // Counts falling edges until the cores are released (bounded).
    task automatic waitRun(output int n);
        n = 0;
        while (bus.core_reset === 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic drainResult();
        bus.res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.res_ready = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (bus.job_ready !== 1'b1 || bus.core_reset !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got ready=%b core_reset=%b busy=%b expected 1 1 0",
                     bus.job_ready, bus.core_reset, bus.busy);
        end
        checks++;
        if (bus.res_valid !== 1'b0 || bus.res_hit !== 1'b0 || bus.res_nonce !== 32'h0 ||
            bus.res_core !== 2'd0) begin
            errors++;
            $display("[TB] FAIL reset_res: got valid=%b hit=%b nonce=%h core=%0d expected all 0",
                     bus.res_valid, bus.res_hit, bus.res_nonce, bus.res_core);
        end
        checks++;
        if (bus.core_block !== '0 || bus.core_nonce_start !== '0) begin
            errors++;
            $display("[TB] FAIL reset_core_bus: got nonce_start=%h expected 0", bus.core_nonce_start);
        end
        advance(2);
        reset_n = 1'b1;
        advance(1);
        checks++;
        if (bus.job_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: got ready=%b busy=%b expected 1 0",
                     bus.job_ready, bus.busy);
        end
    endtask

    task automatic test_hit();
        int loads;
        applyStimulus(32'h100, 32'h1FF);
        checks++;
        if (bus.core_nonce_start !== {32'h103, 32'h102, 32'h101, 32'h100}) begin
            errors++;
            $display("[TB] FAIL hit_nonce_start: got %h expected 00000103000001020000010100000100",
                     bus.core_nonce_start);
        end
        checks++;
        if (bus.core_block !== blk) begin
            errors++;
            $display("[TB] FAIL hit_core_block: got %h expected %h", bus.core_block[63:0], blk[63:0]);
        end
        checks++;
        if (bus.job_ready !== 1'b0 || bus.busy !== 1'b1 || bus.core_reset !== 1'b1) begin
            errors++;
            $display("[TB] FAIL hit_load: got ready=%b busy=%b core_reset=%b expected 0 1 1",
                     bus.job_ready, bus.busy, bus.core_reset);
        end
        waitRun(loads);
        checks++;
        if (loads != 2) begin
            errors++;
            $display("[TB] FAIL hit_load_len: got %0d expected 2", loads);
        end
        advance(4);
        checks++;
        if (bus.res_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hit_early_valid: got %b expected 0", bus.res_valid);
        end
        bus.core_found = 4'b0100;
        setNonce(2, 32'h116);
        advance(1);
        bus.core_found = 4'b0000;
        checks++;
        if (bus.res_valid !== 1'b1 || bus.res_hit !== 1'b1) begin
            errors++;
            $display("[TB] FAIL hit_valid: got valid=%b hit=%b expected 1 1", bus.res_valid, bus.res_hit);
        end
        checks++;
        if (bus.res_core !== 2'd2 || bus.res_nonce !== 32'h112) begin
            errors++;
            $display("[TB] FAIL hit_result: got core=%0d nonce=%h expected 2 00000112",
                     bus.res_core, bus.res_nonce);
        end
        checks++;
        if (bus.core_reset !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hit_report_ctrl: got core_reset=%b busy=%b expected 1 0",
                     bus.core_reset, bus.busy);
        end
        drainResult();
        checks++;
        if (bus.res_valid !== 1'b0 || bus.job_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL hit_drain: got valid=%b ready=%b expected 0 1", bus.res_valid, bus.job_ready);
        end
    endtask

    task automatic test_tie();
        int loads;
        applyStimulus(32'h200, 32'h2FF);
        waitRun(loads);
        advance(2);
        bus.core_found = 4'b1010;
        setNonce(1, 32'h20A);
        setNonce(3, 32'h20C);
        advance(1);
        bus.core_found = 4'b0000;
        checks++;
        if (bus.res_valid !== 1'b1 || bus.res_core !== 2'd1 || bus.res_nonce !== 32'h206) begin
            errors++;
            $display("[TB] FAIL tie_pick: got valid=%b core=%0d nonce=%h expected 1 1 00000206",
                     bus.res_valid, bus.res_core, bus.res_nonce);
        end
        drainResult();
    endtask

    task automatic test_miss();
        int loads;
        int n;
        applyStimulus(32'h0, 32'hF);
        waitRun(loads);
        advance(3);
        checks++;
        if (bus.res_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL miss_early: got %b expected 0", bus.res_valid);
        end
        n = 0;
        while (bus.res_valid !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.res_valid !== 1'b1 || bus.res_hit !== 1'b0) begin
            errors++;
            $display("[TB] FAIL miss_result: got valid=%b hit=%b expected 1 0", bus.res_valid, bus.res_hit);
        end
        drainResult();
    endtask

    task automatic test_backpressure();
        int loads;
        int bad;
        applyStimulus(32'h300, 32'h3FF);
        waitRun(loads);
        advance(2);
        bus.core_found = 4'b0001;
        setNonce(0, 32'h310);
        advance(1);
        bus.core_found = 4'b0000;
        bus.job_valid  = 1'b1;
        checks++;
        if (bus.res_valid !== 1'b1 || bus.res_core !== 2'd0 || bus.res_nonce !== 32'h30C) begin
            errors++;
            $display("[TB] FAIL bp_result: got valid=%b core=%0d nonce=%h expected 1 0 0000030C",
                     bus.res_valid, bus.res_core, bus.res_nonce);
        end
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            bus.abort = (c == 5);
            advance(1);
            if (bus.res_valid !== 1'b1 || bus.res_hit !== 1'b1 || bus.res_nonce !== 32'h30C ||
                bus.res_core !== 2'd0 || bus.job_ready !== 1'b0 || bus.core_reset !== 1'b1)
                bad++;
        end
        bus.abort     = 1'b0;
        bus.job_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL bp_hold: got %0d unstable cycles expected 0", bad);
        end
        drainResult();
        checks++;
        if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0 || bus.job_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_drain: got valid=%b busy=%b ready=%b expected 0 0 1",
                     bus.res_valid, bus.busy, bus.job_ready);
        end
    endtask

    task automatic test_abort();
        int loads;
        int seen;
        applyStimulus(32'h400, 32'h4FF);
        waitRun(loads);
        advance(2);
        bus.abort = 1'b1;
        advance(1);
        bus.abort = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.job_ready !== 1'b1 || bus.core_reset !== 1'b1 ||
            bus.res_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_run: got busy=%b ready=%b core_reset=%b valid=%b expected 0 1 1 0",
                     bus.busy, bus.job_ready, bus.core_reset, bus.res_valid);
        end
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            advance(1);
            if (bus.res_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("[TB] FAIL abort_no_result: got %0d valid cycles expected 0", seen);
        end
        applyStimulus(32'h480, 32'h4FF);
        checks++;
        if (bus.busy !== 1'b1 || bus.core_nonce_start[31:0] !== 32'h480) begin
            errors++;
            $display("[TB] FAIL abort_new_job: got busy=%b start0=%h expected 1 00000480",
                     bus.busy, bus.core_nonce_start[31:0]);
        end
        bus.abort = 1'b1;
        advance(1);
        bus.abort = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.job_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_load: got busy=%b ready=%b expected 0 1", bus.busy, bus.job_ready);
        end
    endtask

    task automatic test_mask();
        int loads;
        applyStimulus(32'h500, 32'h5FF);
        waitRun(loads);
        bus.core_found = 4'b0001;
        setNonce(0, 32'h501);
        advance(2);
        bus.core_found = 4'b0000;
        checks++;
        if (bus.res_valid !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mask_cycle3: got valid=%b busy=%b expected 0 1", bus.res_valid, bus.busy);
        end
        advance(1);
        checks++;
        if (bus.res_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mask_cycle4: got valid=%b expected 0", bus.res_valid);
        end
        bus.core_found = 4'b1000;
        setNonce(3, 32'h520);
        advance(1);
        bus.core_found = 4'b0000;
        checks++;
        if (bus.res_valid !== 1'b1 || bus.res_core !== 2'd3 || bus.res_nonce !== 32'h51C) begin
            errors++;
            $display("[TB] FAIL mask_hit: got valid=%b core=%0d nonce=%h expected 1 3 0000051C",
                     bus.res_valid, bus.res_core, bus.res_nonce);
        end
        drainResult();
    endtask

    task automatic test_async_reset();
        int loads;
        applyStimulus(32'h600, 32'h6FF);
        waitRun(loads);
        advance(2);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.job_ready !== 1'b1 || bus.core_reset !== 1'b1 || bus.busy !== 1'b0 ||
            bus.res_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL areset_ctrl: got ready=%b core_reset=%b busy=%b valid=%b expected 1 1 0 0",
                     bus.job_ready, bus.core_reset, bus.busy, bus.res_valid);
        end
        checks++;
        if (bus.res_hit !== 1'b0 || bus.res_nonce !== 32'h0 || bus.res_core !== 2'd0 ||
            bus.core_block !== '0 || bus.core_nonce_start !== '0) begin
            errors++;
            $display("[TB] FAIL areset_data: got hit=%b nonce=%h core=%0d start=%h expected all 0",
                     bus.res_hit, bus.res_nonce, bus.res_core, bus.core_nonce_start);
        end
        advance(2);
        reset_n = 1'b1;
        advance(1);
    endtask

    initial begin
        reset_n       = 1'b1;
        bus.job_valid = 1'b0;
        bus.job_start = '0;
        bus.job_last  = '0;
        bus.job_block = '0;
        bus.abort     = 1'b0;
        bus.core_found = '0;
        bus.core_nonce = '0;
        bus.res_ready = 1'b0;
        for (int w = 0; w < HDR_W / 32; w++) blk[w*32 +: 32] = 32'hC0DE0000 + 32'(w);
        #1 reset_n = 1'b0;
        test_reset();
        test_hit();
        test_tie();
        test_miss();
        test_backpressure();
        test_abort();
        test_mask();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
